psone_key_scheduler: RTL and testbench

Time-multiplexed debounce and event scheduler for the PlayStation-style gamepad button bank. One shared counter-update datapath is scanned round-robin across all KEYS raw button lines, giving each key its own debounce counter without replicating the logic per key. Debounced transitions are queued as key events for the USB report builder, which drains them through a valid/ready handshake.

---
 rtl/psone_pkg.sv | 43 ++++
 rtl/psone_evt_fifo.sv | 70 +++++++
 rtl/psone_key_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_psone_key_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psone_pkg.sv
// -----------------------------------------------------------------------------
// psone_pkg
// Shared definitions for the PlayStation-style gamepad key scheduler.
//   - event word layout: {press, key_index}, key index in the low bits
//   - button index constants (SELECT=0 ... SQUARE=15)
//   - default per-key debounce counter width
// -----------------------------------------------------------------------------
package psone_pkg;

    localparam int PSONE_DEBOUNCE_W_DEFAULT = 11;

    // Key index occupies the low bits of an event word, the press flag sits
    // directly above it.
    localparam int EVT_KEY_LSB = 0;

    function automatic int evt_press_bit(input int kw);
        return EVT_KEY_LSB + kw;
    endfunction

    function automatic int evt_width(input int kw);
        return kw + 1;
    endfunction

    typedef enum logic [5:0] {
        BTN_SELECT   = 6'd0,
        BTN_L3       = 6'd1,
        BTN_R3       = 6'd2,
        BTN_START    = 6'd3,
        BTN_UP       = 6'd4,
        BTN_RIGHT    = 6'd5,
        BTN_DOWN     = 6'd6,
        BTN_LEFT     = 6'd7,
        BTN_L2       = 6'd8,
        BTN_R2       = 6'd9,
        BTN_L1       = 6'd10,
        BTN_R1       = 6'd11,
        BTN_TRIANGLE = 6'd12,
        BTN_CIRCLE   = 6'd13,
        BTN_CROSS    = 6'd14,
        BTN_SQUARE   = 6'd15
    } psone_button_e;

endpackage

// File: rtl/psone_evt_fifo.sv
// -----------------------------------------------------------------------------
// psone_evt_fifo
// Synchronous show-ahead FIFO holding key events.
// Ports:
//   iCLK   in  clock
//   iRESET in  asynchronous active-low reset (empties the FIFO)
//   push   in  write din this cycle (ignored when full unless pop also occurs)
//   din    in  W-bit event word
//   pop    in  remove head this cycle (ignored when empty)
//   dout   out head entry, valid whenever empty is low
//   full   out DEPTH entries stored
//   empty  out no entries stored
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module psone_evt_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 8
) (
    input  logic         iCLK,
    input  logic         iRESET,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is legal when the head leaves in the same cycle:
    // the write lands in the slot being vacated.
    always_comb begin
        full    = (count == (AW+1)'(DEPTH));
        empty   = (count == '0);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        dout    = mem[rd_ptr];
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset; contents are only observed when not empty.
    always_ff @(posedge iCLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/psone_key_scheduler.sv
// -----------------------------------------------------------------------------
// psone_key_scheduler
// Time-multiplexed debounce and event scheduler for the gamepad button bank.
// One counter-update datapath is scanned round-robin over all KEYS lines; each
// debounced transition is queued as an event for the report builder.
// Ports:
//   iCLK          in  system clock
//   iRESET        in  asynchronous active-low reset
//   iKEY          in  KEYS raw active-low buttons (asynchronous)
//   oKEYS_STABLE  out KEYS debounced levels (0 = pressed)
//   oEVT_VALID    out event FIFO head valid
//   oEVT_KEY      out KW key index of head event
//   oEVT_PRESS    out 1 = press, 0 = release
//   iEVT_READY    in  consumer accepts head when high with oEVT_VALID
//   oOVERFLOW     out sticky: an event was dropped
//   iCLR_OVF      in  one-cycle clear of oOVERFLOW (a same-cycle set wins)
// Build option: define PSONE_KEY_RELEASE_EN to queue release events as well;
// without it only presses are queued and oEVT_PRESS is tied to 1.
// -----------------------------------------------------------------------------
module psone_key_scheduler
    import psone_pkg::*;
#(
    parameter  int KEYS  = 16,
    parameter  int N     = PSONE_DEBOUNCE_W_DEFAULT,
    parameter  int DEPTH = 8,
    localparam int KW    = $clog2(KEYS)
) (
    input  logic            iCLK,
    input  logic            iRESET,
    input  logic [KEYS-1:0] iKEY,
    output logic [KEYS-1:0] oKEYS_STABLE,
    output logic            oEVT_VALID,
    output logic [KW-1:0]   oEVT_KEY,
    output logic            oEVT_PRESS,
    input  logic            iEVT_READY,
    output logic            oOVERFLOW,
    input  logic            iCLR_OVF
);

    localparam int EW = evt_width(KW);
    localparam int PB = evt_press_bit(KW);

    logic [KEYS-1:0] sync1;
    logic [KEYS-1:0] sync2;
    logic [KEYS-1:0] last;
    logic [KEYS-1:0] stable;
    logic [N-1:0]    cnt [KEYS];
    logic [KW-1:0]   idx;

    logic            s;
    logic [N-1:0]    cur_cnt;
    logic            commit;
    logic            push_req;

    logic            pend_valid;
    logic [KW-1:0]   pend_key;
    logic            pend_press;

    logic [EW-1:0]   fifo_din;
    logic [EW-1:0]   fifo_dout;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            pop;
    logic            ovf_set;

    // Two-flop synchronizer; idle (released) level is 1.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= iKEY;
            sync2 <= sync1;
        end
    end

    // Round-robin scan pointer over all key lines.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            idx <= '0;
        end else if (idx == KW'(KEYS-1)) begin
            idx <= '0;
        end else begin
            idx <= idx + KW'(1);
        end
    end

    // Visit decode for the currently scanned key. A commit needs the sample to
    // match the last one, a saturated counter, and a differing stable level.
    always_comb begin
        s        = sync2[idx];
        cur_cnt  = cnt[idx];
        commit   = (s == last[idx]) && cur_cnt[N-1] && (stable[idx] != s);
`ifdef PSONE_KEY_RELEASE_EN
        push_req = commit;
`else
        push_req = commit && !s;
`endif
    end

    // Shared counter-update datapath: only the visited key's state changes.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            last   <= '1;
            stable <= '1;
            for (int i = 0; i < KEYS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            if (s != last[idx]) begin
                cnt[idx]  <= '0;
                last[idx] <= s;
            end else if (!cur_cnt[N-1]) begin
                cnt[idx]  <= cur_cnt + N'(1);
            end else if (stable[idx] != s) begin
                stable[idx] <= s;
            end
        end
    end

    // Commit stage: the event is pushed one cycle after stable updates.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            pend_valid <= 1'b0;
            pend_key   <= '0;
            pend_press <= 1'b0;
        end else begin
            pend_valid <= push_req;
            pend_key   <= idx;
            pend_press <= !s;
        end
    end

    always_comb begin
        pop       = !fifo_empty && iEVT_READY;
        fifo_push = pend_valid && (!fifo_full || pop);
        ovf_set   = pend_valid && fifo_full && !pop;
        fifo_din  = '0;
        fifo_din[EVT_KEY_LSB +: KW] = pend_key;
        fifo_din[PB] = pend_press;
    end

    psone_evt_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .push   (fifo_push),
        .din    (fifo_din),
        .pop    (pop),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            oOVERFLOW <= 1'b0;
        end else if (ovf_set) begin
            oOVERFLOW <= 1'b1;
        end else if (iCLR_OVF) begin
            oOVERFLOW <= 1'b0;
        end
    end

    // Head outputs are forced to zero while the FIFO is empty so the reset
    // values are defined regardless of the uninitialised storage.
    always_comb begin
        oKEYS_STABLE = stable;
        oEVT_VALID   = !fifo_empty;
        oEVT_KEY     = fifo_empty ? '0 : fifo_dout[EVT_KEY_LSB +: KW];
    end

`ifdef PSONE_KEY_RELEASE_EN
    assign oEVT_PRESS = fifo_empty ? 1'b0 : fifo_dout[PB];
`else
    logic unused_head_press;
    assign unused_head_press = fifo_dout[PB];
    assign oEVT_PRESS = 1'b1;
`endif

endmodule

// File: tb/tb_psone_key_scheduler.sv
// -----------------------------------------------------------------------------
// tb_psone_key_scheduler
// Self-checking bench for psone_key_scheduler (KEYS=16, N=4, DEPTH=8).
// A behavioural model (steady-visit counts per key plus an event queue) runs
// alongside the DUT; directed steps also check fixed expectations.
// Honors PSONE_KEY_RELEASE_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_psone_key_scheduler;

    localparam int KEYS   = 16;
    localparam int N      = 4;
    localparam int DEPTH  = 8;
    localparam int COMMIT = (1 << (N-1)) + 1;
`ifdef PSONE_KEY_RELEASE_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    logic            iCLK;
    logic            iRESET;
    logic [KEYS-1:0] iKEY;
    logic [KEYS-1:0] oKEYS_STABLE;
    logic            oEVT_VALID;
    logic [3:0]      oEVT_KEY;
    logic            oEVT_PRESS;
    logic            iEVT_READY;
    logic            oOVERFLOW;
    logic            iCLR_OVF;

    int testsRun  = 0;
    int failCount = 0;

    psone_key_scheduler #(
        .KEYS  (KEYS),
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .iCLK         (iCLK),
        .iRESET       (iRESET),
        .iKEY         (iKEY),
        .oKEYS_STABLE (oKEYS_STABLE),
        .oEVT_VALID   (oEVT_VALID),
        .oEVT_KEY     (oEVT_KEY),
        .oEVT_PRESS   (oEVT_PRESS),
        .iEVT_READY   (iEVT_READY),
        .oOVERFLOW    (oOVERFLOW),
        .iCLR_OVF     (iCLR_OVF)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Behavioural reference: per key, how many consecutive visits have seen
    // the same synchronized level; a key commits on its COMMIT-th steady visit.
    typedef struct packed {
        logic [3:0] key;
        logic       press;
    } mevt_t;

    logic [KEYS-1:0] m_sync1, m_sync2, m_last, m_stable;
    int              m_steady [KEYS];
    int              m_idx;
    mevt_t           m_fifo [$];
    bit              m_pend_v;
    mevt_t           m_pend;
    bit              m_ovf;

    always @(posedge iCLK or negedge iRESET) begin : model
        bit    s;
        bit    dropped;
        mevt_t e;
        if (!iRESET) begin
            m_sync1  = '1;
            m_sync2  = '1;
            m_last   = '1;
            m_stable = '1;
            for (int k = 0; k < KEYS; k++) m_steady[k] = 0;
            m_idx    = 0;
            m_fifo.delete();
            m_pend_v = 0;
            m_ovf    = 0;
        end else begin
            if (m_fifo.size() != 0 && iEVT_READY) void'(m_fifo.pop_front());
            dropped = 0;
            if (m_pend_v) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(m_pend);
                else dropped = 1;
            end
            if (dropped) m_ovf = 1;
            else if (iCLR_OVF) m_ovf = 0;
            m_pend_v = 0;
            s = m_sync2[m_idx];
            if (s != m_last[m_idx]) begin
                m_last[m_idx]   = s;
                m_steady[m_idx] = 0;
            end else begin
                if (m_steady[m_idx] < COMMIT) m_steady[m_idx]++;
                if (m_steady[m_idx] >= COMMIT && m_stable[m_idx] != s) begin
                    m_stable[m_idx] = s;
                    if (REL_EN || !s) begin
                        e.key    = 4'(m_idx);
                        e.press  = !s;
                        m_pend   = e;
                        m_pend_v = 1;
                    end
                end
            end
            m_sync2 = m_sync1;
            m_sync1 = iKEY;
            m_idx   = (m_idx + 1) % KEYS;
        end
    end

    task automatic applyStimulus(input logic [KEYS-1:0] keys, input logic ready,
                                 input logic clr);
        iKEY       = keys;
        iEVT_READY = ready;
        iCLR_OVF   = clr;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge iCLK);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Compare every output against the reference model.
    task automatic checkModel(input string tag);
        bit    mv;
        mevt_t h;
        mv = (m_fifo.size() != 0);
        h  = mv ? m_fifo[0] : '0;
        checkOutput({tag, ".stable"}, 64'(oKEYS_STABLE), 64'(m_stable));
        checkOutput({tag, ".valid"},  64'(oEVT_VALID),   64'(mv));
        checkOutput({tag, ".ovf"},    64'(oOVERFLOW),    64'(m_ovf));
        checkOutput({tag, ".key"},    64'(oEVT_KEY),     64'(h.key));
        checkOutput({tag, ".press"},  64'(oEVT_PRESS),   64'(REL_EN ? h.press : 1'b1));
    endtask

    // Count accepted events over a window and remember the first one.
    task automatic countPops(input int cycles, output int n, output int fkey,
                             output bit fpress, output int fcycle);
        n = 0; fkey = -1; fpress = 0; fcycle = -1;
        for (int c = 1; c <= cycles; c++) begin
            @(negedge iCLK);
            if (oEVT_VALID && iEVT_READY) begin
                if (n == 0) begin
                    fkey   = int'(oEVT_KEY);
                    fpress = oEVT_PRESS;
                    fcycle = c;
                end
                n++;
            end
        end
    endtask

    initial begin : stimulus
        int              n, fkey, fcycle;
        bit              fpress;
        logic [KEYS-1:0] keys;

        // Reset with random raw inputs.
        iRESET = 1'b0;
        applyStimulus('1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge iCLK);
            iKEY = KEYS'($urandom);
        end
        checkOutput("rst.stable", 64'(oKEYS_STABLE), 64'hFFFF);
        checkOutput("rst.valid",  64'(oEVT_VALID), 64'd0);
        checkOutput("rst.ovf",    64'(oOVERFLOW), 64'd0);
        checkOutput("rst.key",    64'(oEVT_KEY), 64'd0);
        checkOutput("rst.press",  64'(oEVT_PRESS), 64'(REL_EN ? 1'b0 : 1'b1));
        applyStimulus('1, 1'b1, 1'b0);
        iRESET = 1'b1;
        tick(40);
        checkModel("idle");

        // Single press of key 3.
        keys = '1; keys[3] = 1'b0;
        applyStimulus(keys, 1'b1, 1'b0);
        countPops(200, n, fkey, fpress, fcycle);
        checkOutput("press.count", 64'(n), 64'd1);
        checkOutput("press.key", 64'(fkey), 64'd3);
        checkOutput("press.press", 64'(fpress), 64'd1);
        checkOutput("press.latency_ok", 64'(fcycle >= 1 && fcycle <= 163), 64'd1);
        checkOutput("press.stable3", 64'(oKEYS_STABLE[3]), 64'd0);
        checkModel("press");

        // Bounce on key 5: toggles faster than a debounce period.
        n = 0;
        for (int t = 0; t < 25; t++) begin
            int k;
            keys[5] = ~keys[5];
            applyStimulus(keys, 1'b1, 1'b0);
            countPops(40, k, fkey, fpress, fcycle);
            n += k;
        end
        keys[5] = 1'b1;
        applyStimulus(keys, 1'b1, 1'b0);
        countPops(200, fcycle, fkey, fpress, fcycle);
        checkOutput("bounce.events", 64'(n), 64'd0);
        checkOutput("bounce.stable5", 64'(oKEYS_STABLE[5]), 64'd1);
        checkModel("bounce");

        // Release key 3.
        keys[3] = 1'b1;
        applyStimulus(keys, 1'b1, 1'b0);
        countPops(200, n, fkey, fpress, fcycle);
        checkOutput("release.count", 64'(n), 64'(REL_EN ? 1 : 0));
        if (REL_EN) begin
            checkOutput("release.key", 64'(fkey), 64'd3);
            checkOutput("release.press", 64'(fpress), 64'd0);
        end
        checkOutput("release.stable3", 64'(oKEYS_STABLE[3]), 64'd1);

        // Randomized segments checked against the model.
        for (int seg = 0; seg < 20; seg++) begin
            int len;
            bit stall;
            keys  = KEYS'($urandom);
            len   = $urandom_range(20, 250);
            stall = ($urandom_range(0, 4) == 0);
            for (int c = 0; c < len; c++) begin
                applyStimulus(keys, stall ? 1'b0 : ($urandom_range(0, 3) != 0),
                              ($urandom_range(0, 49) == 0));
                @(negedge iCLK);
                if ((c % 4) == 0) checkModel("random");
            end
        end
        applyStimulus('1, 1'b1, 1'b1);
        tick(1);
        applyStimulus('1, 1'b1, 1'b0);
        tick(400);
        checkModel("settle");
        checkOutput("settle.valid", 64'(oEVT_VALID), 64'd0);
        checkOutput("settle.ovf", 64'(oOVERFLOW), 64'd0);

        // Overflow: keys 0..8 together, aligned so key 0 is visited first.
        applyStimulus('1, 1'b0, 1'b0);
        for (int c = 0; c < 20 && m_idx != 14; c++) @(negedge iCLK);
        checkOutput("ovf.align", 64'(m_idx), 64'd14);
        applyStimulus(16'hFE00, 1'b0, 1'b0);
        tick(200);
        checkOutput("ovf.flag", 64'(oOVERFLOW), 64'd1);
        checkOutput("ovf.stable8", 64'(oKEYS_STABLE[8]), 64'd0);
        checkOutput("ovf.stable", 64'(oKEYS_STABLE), 64'hFE00);
        checkModel("ovf");
        applyStimulus(16'hFE00, 1'b0, 1'b1);
        tick(1);
        applyStimulus(16'hFE00, 1'b0, 1'b0);
        checkOutput("ovf.clear", 64'(oOVERFLOW), 64'd0);

        // Backpressure: head holds while not ready.
        for (int c = 0; c < 5; c++) begin
            tick(1);
            checkOutput("hold.valid", 64'(oEVT_VALID), 64'd1);
            checkOutput("hold.key", 64'(oEVT_KEY), 64'd0);
            checkOutput("hold.press", 64'(oEVT_PRESS), 64'd1);
        end

        // Drain one event per cycle in scan order.
        applyStimulus(16'hFE00, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checkOutput("drain.valid", 64'(oEVT_VALID), 64'd1);
            checkOutput("drain.key", 64'(oEVT_KEY), 64'(i));
            checkOutput("drain.press", 64'(oEVT_PRESS), 64'd1);
            tick(1);
        end
        checkOutput("drain.empty", 64'(oEVT_VALID), 64'd0);
        checkModel("drain");

        // Reset mid-debounce discards the pending commit.
        applyStimulus('1, 1'b1, 1'b0);
        tick(300);
        keys = '1; keys[3] = 1'b0;
        applyStimulus(keys, 1'b1, 1'b0);
        tick(60);
        iRESET = 1'b0;
        tick(3);
        checkOutput("midrst.stable", 64'(oKEYS_STABLE), 64'hFFFF);
        checkOutput("midrst.valid", 64'(oEVT_VALID), 64'd0);
        checkOutput("midrst.ovf", 64'(oOVERFLOW), 64'd0);
        applyStimulus('1, 1'b1, 1'b0);
        iRESET = 1'b1;
        countPops(250, n, fkey, fpress, fcycle);
        checkOutput("midrst.events", 64'(n), 64'd0);
        checkOutput("midrst.stable3", 64'(oKEYS_STABLE[3]), 64'd1);
        checkModel("midrst");

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
